// File: rtl/lockstep_pkg.sv
// Shared register map offsets, resync FSM states and byte-enable helper for the lockstep controller.
// Latency: n/a (types and constants only); backpressure: n/a.
package lockstep_pkg;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_STATUS   = 8'h04;
    localparam logic [7:0] OFF_IRQ_MASK = 8'h08;
    localparam logic [7:0] OFF_RESYNC   = 8'h0C;
    localparam logic [7:0] OFF_CNT_BASE = 8'h10;

    typedef enum logic {
        RS_IDLE,
        RS_REQ
    } rs_state_e;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/lockstep_ctrl_unit_if.sv
// Peripheral-interconnect slave port: request channel plus registered response channel.
// Latency: response one cycle after request; backpressure: none, grant is tied high.
interface lockstep_ctrl_unit_if #(
    parameter int ID_WIDTH = 5
);
    logic                req_i;
    logic [31:0]         addr_i;
    logic                wen_i;
    logic [31:0]         wdata_i;
    logic [3:0]          be_i;
    logic [ID_WIDTH-1:0] id_i;
    logic                gnt_o;
    logic                r_valid_o;
    logic                r_opc_o;
    logic [ID_WIDTH-1:0] r_id_o;
    logic [31:0]         r_rdata_o;

    modport master (
        output req_i, addr_i, wen_i, wdata_i, be_i, id_i,
        input  gnt_o, r_valid_o, r_opc_o, r_id_o, r_rdata_o
    );

    modport slave (
        input  req_i, addr_i, wen_i, wdata_i, be_i, id_i,
        output gnt_o, r_valid_o, r_opc_o, r_id_o, r_rdata_o
    );
endinterface

// File: rtl/lockstep_pair_ctrl.sv
// Per-pair sticky mismatch flag, saturating mismatch counter and resync request FSM.
// Latency: state updates at the next edge; backpressure: none, resync holds until acked.
module lockstep_pair_ctrl
    import lockstep_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 mismatch_i,
    input  logic                 status_clr_i,
    input  logic                 cnt_clr_i,
    input  logic                 resync_start_i,
    input  logic                 resync_ack_i,
    output logic                 status_o,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 busy_o,
    output logic                 resync_req_o
);

    rs_state_e            state_q, state_d;
    logic                 status_q, status_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 counted;
    logic                 ack_clr;

    assign counted = en_i & mismatch_i & (state_q == RS_IDLE);
    assign ack_clr = (state_q == RS_REQ) & resync_ack_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= RS_IDLE;
            status_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        case (state_q)
            RS_IDLE: if (resync_start_i) state_d = RS_REQ;
            RS_REQ:  if (resync_ack_i)   state_d = RS_IDLE;
            default: state_d = RS_IDLE;
        endcase
        // Precedence: resync completion clear, then a new mismatch, then software clear.
        if (ack_clr) begin
            status_d = 1'b0;
            cnt_d    = '0;
        end else begin
            if (counted) begin
                status_d = 1'b1;
            end else if (status_clr_i) begin
                status_d = 1'b0;
            end
            if (counted) begin
                if (cnt_clr_i) begin
                    cnt_d = CNT_WIDTH'(1);
                end else if (!(&cnt_q)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (cnt_clr_i) begin
                cnt_d = '0;
            end
        end
    end

    assign status_o     = status_q;
    assign cnt_o        = cnt_q;
    assign busy_o       = (state_q == RS_REQ);
    assign resync_req_o = (state_q == RS_REQ);

endmodule

// File: rtl/lockstep_ctrl_unit.sv
// Memory-mapped lockstep controller: decode, CTRL/IRQ_MASK registers, per-pair blocks, response stage.
// Latency: one-cycle registered response; backpressure: none, every request is granted.
module lockstep_ctrl_unit
    import lockstep_pkg::*;
#(
    parameter int          ID_WIDTH  = 5,
    parameter logic [31:0] BASE_ADDR = 32'h1020_4400,
    parameter int          N_PAIRS   = 4,
    parameter int          CNT_WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    lockstep_ctrl_unit_if.slave bus,
    input  logic [N_PAIRS-1:0] mismatch_i,
    output logic [N_PAIRS-1:0] lockstep_en_o,
    output logic [N_PAIRS-1:0] resync_req_o,
    input  logic [N_PAIRS-1:0] resync_ack_i,
    output logic               irq_o
);

    logic [N_PAIRS-1:0]   ctrl_q, mask_q;
    logic [N_PAIRS-1:0]   status, busy, cnt_clr;
    logic [CNT_WIDTH-1:0] cnt [N_PAIRS];

    logic        in_win, wr, mapped, opc_d;
    logic        is_ctrl, is_status, is_mask, is_resync, is_cnt;
    logic [5:0]  off, cnt_idx;
    logic [31:0] bm, ctrl_new, mask_new, w1c_vec, start_vec, rdata_d;
    logic        unused_bits;

    always_comb begin
        in_win    = (bus.addr_i[31:8] == BASE_ADDR[31:8]);
        off       = bus.addr_i[7:2];
        cnt_idx   = off - OFF_CNT_BASE[7:2];
        is_ctrl   = (off == OFF_CTRL[7:2]);
        is_status = (off == OFF_STATUS[7:2]);
        is_mask   = (off == OFF_IRQ_MASK[7:2]);
        is_resync = (off == OFF_RESYNC[7:2]);
        is_cnt    = (off >= OFF_CNT_BASE[7:2]) && (cnt_idx < 6'(N_PAIRS));
        mapped    = is_ctrl | is_status | is_mask | is_resync | is_cnt;
        wr        = bus.req_i & ~bus.wen_i & in_win;
        bm        = be_mask(bus.be_i);
        ctrl_new  = (32'(ctrl_q) & ~bm) | (bus.wdata_i & bm);
        mask_new  = (32'(mask_q) & ~bm) | (bus.wdata_i & bm);
        w1c_vec   = (wr & is_status) ? (bus.wdata_i & bm) : '0;
        start_vec = (wr & is_resync) ? (bus.wdata_i & bm) : '0;
        for (int i = 0; i < N_PAIRS; i++) begin
            cnt_clr[i] = wr & is_cnt & (cnt_idx == 6'(i)) & (|bus.be_i);
        end
    end

    // Read data and error flag for the request of this cycle; out-of-window and unmapped answer opc=1.
    always_comb begin
        rdata_d = '0;
        opc_d   = ~(in_win & mapped);
        if (bus.wen_i && in_win) begin
            if (is_ctrl)   rdata_d = 32'(ctrl_q);
            if (is_status) rdata_d = 32'(status);
            if (is_mask)   rdata_d = 32'(mask_q);
            if (is_resync) rdata_d = 32'(busy);
            if (is_cnt) begin
                for (int i = 0; i < N_PAIRS; i++) begin
                    if (cnt_idx == 6'(i)) rdata_d = 32'(cnt[i]);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q <= '0;
            mask_q <= '0;
        end else begin
            if (wr && is_ctrl) ctrl_q <= ctrl_new[N_PAIRS-1:0];
            if (wr && is_mask) mask_q <= mask_new[N_PAIRS-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.r_valid_o <= 1'b0;
            bus.r_opc_o   <= 1'b0;
            bus.r_id_o    <= '0;
            bus.r_rdata_o <= '0;
        end else begin
            bus.r_valid_o <= bus.req_i;
            if (bus.req_i) begin
                bus.r_opc_o   <= opc_d;
                bus.r_id_o    <= bus.id_i;
                bus.r_rdata_o <= rdata_d;
            end
        end
    end

    for (genvar g = 0; g < N_PAIRS; g++) begin : g_pair
        lockstep_pair_ctrl #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_pair (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .en_i           (ctrl_q[g]),
            .mismatch_i     (mismatch_i[g]),
            .status_clr_i   (w1c_vec[g]),
            .cnt_clr_i      (cnt_clr[g]),
            .resync_start_i (start_vec[g]),
            .resync_ack_i   (resync_ack_i[g]),
            .status_o       (status[g]),
            .cnt_o          (cnt[g]),
            .busy_o         (busy[g]),
            .resync_req_o   (resync_req_o[g])
        );
    end

    assign bus.gnt_o     = 1'b1;
    assign lockstep_en_o = ctrl_q;
    assign irq_o         = |(status & mask_q);
    assign unused_bits   = ^{bus.addr_i[1:0], ctrl_new, mask_new, w1c_vec, start_vec};

endmodule

// File: tb/tb_lockstep_ctrl_unit.sv
// Directed bench for lockstep_ctrl_unit: scoreboard queue of expected responses, negedge monitor.
module tb_lockstep_ctrl_unit;
    localparam logic [31:0] B = 32'h1020_4400;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] mismatch_i, resync_ack_i, lockstep_en_o, resync_req_o;
    logic       irq_o;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    typedef struct {
        string       nm;
        logic [4:0]  id;
        logic        opc;
        logic [31:0] rd;
        bit          chk_rd;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    lockstep_ctrl_unit_if #(.ID_WIDTH(5)) bus_if ();

    lockstep_ctrl_unit #(
        .ID_WIDTH (5), .BASE_ADDR (B), .N_PAIRS (4), .CNT_WIDTH (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .bus           (bus_if.slave),
        .mismatch_i    (mismatch_i),
        .lockstep_en_o (lockstep_en_o),
        .resync_req_o  (resync_req_o),
        .resync_ack_i  (resync_ack_i),
        .irq_o         (irq_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: every response must match the head of the queue in the cycle it was promised.
    always @(negedge clk_i) begin
        exp_t e;
        if (bus_if.r_valid_o) begin
            n_vec++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp: got id=%h opc=%b rd=%h, required no response", bus_if.r_id_o, bus_if.r_opc_o, bus_if.r_rdata_o);
            end else begin
                e = sbq.pop_front();
                if (e.cyc != cyc || bus_if.r_id_o != e.id || bus_if.r_opc_o != e.opc ||
                    (e.chk_rd && bus_if.r_rdata_o != e.rd)) begin
                    n_err++;
                    $display("FAIL %s: got cyc=%0d id=%h opc=%b rd=%h, required cyc=%0d id=%h opc=%b rd=%h",
                             e.nm, cyc, bus_if.r_id_o, bus_if.r_opc_o, bus_if.r_rdata_o, e.cyc, e.id, e.opc, e.rd);
                end
            end
        end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s: got no response in cyc=%0d, required one", e.nm, cyc);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic access(input string nm, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic [4:0] id, input bit eopc,
                          input logic [31:0] erd, input bit push = 1'b1);
        exp_t e;
        @(posedge clk_i); #1;
        bus_if.req_i   = 1'b1;
        bus_if.wen_i   = rd;
        bus_if.addr_i  = a;
        bus_if.wdata_i = wd;
        bus_if.be_i    = be;
        bus_if.id_i    = id;
        if (push) begin
            e.nm = nm; e.id = id; e.opc = eopc; e.rd = erd; e.chk_rd = rd; e.cyc = cyc + 1;
            sbq.push_back(e);
        end
    endtask

    task automatic rd(input string nm, input logic [7:0] off, input logic [4:0] id, input logic [31:0] erd);
        access(nm, 1'b1, B + 32'(off), 32'h0, 4'hF, id, 1'b0, erd);
    endtask

    task automatic wr(input string nm, input logic [7:0] off, input logic [31:0] wd, input logic [3:0] be);
        access(nm, 1'b0, B + 32'(off), wd, be, 5'h1F, 1'b0, 32'h0);
    endtask

    task automatic step(input logic [3:0] mm, input logic [3:0] ack);
        @(posedge clk_i); #1;
        bus_if.req_i = 1'b0;
        mismatch_i   = mm;
        resync_ack_i = ack;
    endtask

    initial begin
        rst_ni = 1'b0;
        bus_if.req_i = 1'b0; bus_if.wen_i = 1'b0; bus_if.addr_i = '0;
        bus_if.wdata_i = '0; bus_if.be_i = '0; bus_if.id_i = '0;
        mismatch_i = '0; resync_ack_i = '0;
        #3;
        chk("rst_gnt", 32'(bus_if.gnt_o), 32'h1);
        chk("rst_rvalid", 32'(bus_if.r_valid_o), 32'h0);
        chk("rst_rid_rdata", {27'(bus_if.r_rdata_o), bus_if.r_id_o}, 32'h0);
        chk("rst_outs", {23'h0, irq_o, lockstep_en_o, resync_req_o}, 32'h0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;

        rd("rd_ctrl_reset", 8'h00, 5'h03, 32'h0);
        wr("wr_ctrl_all", 8'h00, 32'hFFFF_FFFF, 4'b0001);
        rd("rd_ctrl_f", 8'h00, 5'h02, 32'hF);
        wr("wr_ctrl_b1", 8'h00, 32'h0, 4'b0010);
        rd("rd_ctrl_b1", 8'h00, 5'h04, 32'hF);
        wr("wr_ctrl_be0", 8'h00, 32'h0, 4'b0000);
        rd("rd_ctrl_be0", 8'h00, 5'h05, 32'hF);
        step(0, 0);
        chk("lockstep_en_f", 32'(lockstep_en_o), 32'hF);

        wr("wr_ctrl_2", 8'h00, 32'h2, 4'hF);
        wr("wr_mask_2", 8'h08, 32'h2, 4'hF);
        rd("rd_mask", 8'h08, 5'h06, 32'h2);
        repeat (3) step(4'b0011, 0);
        step(0, 0);
        chk("irq_set", 32'(irq_o), 32'h1);
        rd("rd_cnt1", 8'h14, 5'h07, 32'h3);
        rd("rd_cnt0_dis", 8'h10, 5'h08, 32'h0);
        rd("rd_status_2", 8'h04, 5'h09, 32'h2);
        wr("w1c_status", 8'h04, 32'h2, 4'hF);
        chk("irq_hold", 32'(irq_o), 32'h1);
        step(0, 0);
        chk("irq_clr", 32'(irq_o), 32'h0);
        rd("rd_status_0", 8'h04, 5'h0A, 32'h0);
        wr("wr_cnt1_clr", 8'h14, 32'h0, 4'b0100);
        rd("rd_cnt1_clr", 8'h14, 5'h0B, 32'h0);

        wr("wr_ctrl_1", 8'h00, 32'h1, 4'hF);
        repeat (6) step(4'b0001, 0);
        step(0, 0);
        rd("rd_cnt0_sat", 8'h10, 5'h0C, 32'h3);
        rd("rd_status_1", 8'h04, 5'h0D, 32'h1);
        step(0, 0);
        chk("irq_masked", 32'(irq_o), 32'h0);

        wr("w1c_status0", 8'h04, 32'h1, 4'hF);
        wr("wr_resync_b1", 8'h0C, 32'h1, 4'b0010);
        step(0, 0);
        chk("resync_no_be", 32'(resync_req_o), 32'h0);
        wr("wr_resync", 8'h0C, 32'h1, 4'b0001);
        step(0, 0);
        chk("resync_req_on", 32'(resync_req_o), 32'h1);
        rd("rd_resync_busy", 8'h0C, 5'h0E, 32'h1);
        step(4'b0001, 0);
        step(4'b0001, 0);
        step(0, 0);
        rd("rd_status_req", 8'h04, 5'h0F, 32'h0);
        rd("rd_cnt0_req", 8'h10, 5'h10, 32'h3);
        step(4'b0001, 4'b0001);
        chk("resync_req_ack_cyc", 32'(resync_req_o), 32'h1);
        step(0, 0);
        chk("resync_req_off", 32'(resync_req_o), 32'h0);
        rd("rd_status_ack", 8'h04, 5'h11, 32'h0);
        rd("rd_cnt0_ack", 8'h10, 5'h12, 32'h0);
        rd("rd_resync_idle", 8'h0C, 5'h13, 32'h0);

        access("rd_off80", 1'b1, B + 32'h80, 32'h0, 4'hF, 5'h14, 1'b1, 32'h0);
        access("rd_oow", 1'b1, B + 32'h100, 32'h0, 4'hF, 5'h15, 1'b1, 32'h0);
        access("rd_cnt4_unmapped", 1'b1, B + 32'h20, 32'h0, 4'hF, 5'h16, 1'b1, 32'h0);
        access("wr_oow", 1'b0, B + 32'h100, 32'h0, 4'hF, 5'h17, 1'b1, 32'h0);
        access("wr_unmapped", 1'b0, B + 32'h40, 32'h0, 4'hF, 5'h18, 1'b1, 32'h0);
        rd("rd_ctrl_kept", 8'h00, 5'h19, 32'h1);

        wr("wr_resync_pre_rst", 8'h0C, 32'h1, 4'b0001);
        step(0, 0);
        chk("resync_pre_rst", 32'(resync_req_o), 32'h1);
        access("rd_dropped", 1'b1, B, 32'h0, 4'hF, 5'h1A, 1'b0, 32'h0, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_outs", {23'h0, irq_o, lockstep_en_o, resync_req_o}, 32'h0);
        chk("mid_rst_gnt", 32'(bus_if.gnt_o), 32'h1);
        bus_if.req_i = 1'b0;
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (3) step(0, 0);
        rd("rd_ctrl_post_rst", 8'h00, 5'h1B, 32'h0);
        rd("rd_resync_post_rst", 8'h0C, 5'h1C, 32'h0);
        repeat (3) step(0, 0);
        chk("sb_drained", 32'(sbq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lockstep_ctrl_unit.md
# lockstep_ctrl_unit

- Memory-mapped lockstep controller for up to 32 core pairs.
- Sits as a slave on the cluster peripheral interconnect at a parametrised base address.
- Per pair it holds:
  - an enable bit;
  - a sticky mismatch flag;
  - a saturating mismatch counter;
  - a resync request/acknowledge handshake.
- Raises a maskable interrupt on any flagged mismatch.
- Every accepted access gets a single-cycle-latency response with full byte-enable support.

## Interface
- ID_WIDTH, 5, width of the transaction ID echoed in the response.
- BASE_ADDR, 32'h1020_4400, byte address of register offset 0x00; the decoded window is 256 bytes.
- N_PAIRS, 4, number of lockstep core pairs, legal range 1..32.
- CNT_WIDTH, 16, mismatch counter width, legal range 1..32.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  request
- addr_i  in  32  byte address
- wen_i  in  1  1 = read, 0 = write
- wdata_i  in  32  write data
- be_i  in  4  byte enables
- id_i  in  ID_WIDTH  transaction ID
- gnt_o  out  1  grant; constant 1
- r_valid_o  out  1  response valid
- r_opc_o  out  1  response error flag
- r_id_o  out  ID_WIDTH  echoed ID
- r_rdata_o  out  32  read data
- mismatch_i  in  N_PAIRS  per-pair compare-mismatch pulse, level-sampled every cycle
- lockstep_en_o  out  N_PAIRS  per-pair enable (CTRL register)
- resync_req_o  out  N_PAIRS  per-pair resync request
- resync_ack_i  in  N_PAIRS  per-pair resync acknowledge
- irq_o  out  1  interrupt, level

## Operation
- A request is in the window when addr_i[31:8] == BASE_ADDR[31:8]. The word offset is addr_i[7:2]; addr_i[1:0] is ignored.
- Out-of-window requests are still granted and answered with r_opc_o=1, r_rdata_o=0, and no register side effect.
- Register map; bits at or above N_PAIRS read 0 and ignore writes:
  - 0x00 CTRL, RW: enable per pair.
  - 0x04 STATUS, W1C: sticky mismatch flag per pair.
  - 0x08 IRQ_MASK, RW.
  - 0x0C RESYNC: writing 1 to bit i starts resync for pair i; reads return the per-pair busy bits.
  - 0x10+4*i CNT[i], i<N_PAIRS: read returns the zero-extended counter; any write with be_i≠0 clears it.
- Unmapped offsets: reads return 0 and writes are ignored, both with r_opc_o=1.
- Writes update only the bytes enabled by be_i. With be_i=0 the write has no effect and r_opc_o=0.
- Mismatch, per pair i:
  - Counted only when CTRL[i]=1 and pair i is not busy resyncing.
  - A counted mismatch sets STATUS[i] and increments CNT[i], saturating at all-ones.
  - A set and a W1C clear of STATUS[i] in the same cycle: the set wins.
  - A count and a clear of CNT[i] in the same cycle: the result is 1.
- Resync FSM, per pair, states IDLE and REQ:
  - IDLE→REQ on a RESYNC write with bit i=1 and the matching byte enabled. A write while in REQ is ignored.
  - In REQ, resync_req_o[i]=1 and busy=1.
  - REQ→IDLE on resync_ack_i[i]=1. In that same cycle STATUS[i] and CNT[i] are cleared, and the clear overrides a coincident mismatch.
  - An ack seen in IDLE is ignored.
- irq_o = OR over pairs of (STATUS & IRQ_MASK), taken combinationally from registered state only.

## Timing
- Reset values: all registers 0, all FSMs IDLE, r_valid_o=0, r_opc_o=0, r_id_o=0, r_rdata_o=0, resync_req_o=0, lockstep_en_o=0, irq_o=0.
- gnt_o=1 in all states, including during reset.
- Request accepted in cycle N: r_valid_o=1 in cycle N+1 for one cycle, with r_id_o, r_opc_o and r_rdata_o all registered.
- Back-to-back requests are supported: one response per cycle, no bubbles.
- Reads return the register value before the edge that ends cycle N. A write in N followed by a read in N+1 returns the new value.
- A register write in cycle N is visible on lockstep_en_o and irq_o in cycle N+1.
- A RESYNC write in cycle N drives resync_req_o[i]=1 from N+1.
- An ack in cycle M drops resync_req_o[i] to 0 in M+1.
- A mismatch sampled in cycle N shows as STATUS/CNT and irq_o in N+1.
- Reset asserted mid-transaction or mid-resync: the response is dropped, all state returns to reset values asynchronously, and no response is produced after reset is released.

## Structure
- Package lockstep_pkg holds:
  - register offset constants (CTRL, STATUS, IRQ_MASK, RESYNC, CNT_BASE);
  - the resync state enum {RS_IDLE, RS_REQ}.
- Sub-module lockstep_pair_ctrl holds the per-pair sticky flag, counter and resync FSM. It is instantiated N_PAIRS times in a generate loop.
- The top level holds the decode, the write strobes, the CTRL/IRQ_MASK registers, the response pipeline and irq_o.

## Test plan
- Reset then read CTRL at BASE_ADDR with id 5'h3 → r_valid_o in the next cycle, r_id_o=3, r_rdata_o=0, r_opc_o=0.
- Write CTRL=32'hFFFF_FFFF with be=4'b0001, N_PAIRS=4, then read → 32'h0000_000F; lockstep_en_o=4'hF.
- CTRL[1]=1, IRQ_MASK[1]=1, pulse mismatch_i[1] for 3 cycles:
  - CNT[1] (offset 0x14) reads 3, STATUS reads 32'h2, irq_o=1.
  - W1C 32'h2 to STATUS → irq_o=0 in the next cycle.
- CNT_WIDTH=2, hold mismatch_i[0] for 6 cycles with CTRL[0]=1 → CNT[0] reads 3, i.e. saturated.
- Write RESYNC=32'h1:
  - resync_req_o[0]=1 next cycle, RESYNC reads 1.
  - Mismatches during REQ are not counted.
  - Ack on the third cycle → req low the next cycle, STATUS[0]=0 and CNT[0]=0.
- Read offset 0x80 with N_PAIRS=4 → r_opc_o=1, r_rdata_o=0. Read address BASE_ADDR+0x100 → r_opc_o=1.
